uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets C_REQ_NUM byte sources share one UART_Tx.
// Optional message lock (owner keeps the UART across bytes) is built with UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_REQ_NUM         = 4,
  parameter int C_BUSY_TIMEOUT    = 16
) (
  input  logic                                   clk,
  input  logic                                   rstb,
  input  logic                                   enable,
  input  logic [C_REQ_NUM-1:0]                   reqSend,
  input  logic [C_REQ_NUM*C_UART_DATA_WIDTH-1:0] reqData,
  input  logic [C_REQ_NUM-1:0]                   reqLock,
  output logic [C_REQ_NUM-1:0]                   reqAck,
  output logic [C_REQ_NUM-1:0]                   grant,
  output logic                                   busy,
  output logic                                   error,
  input  logic                                   txBusy,
  output logic                                   txSend,
  output logic [C_UART_DATA_WIDTH-1:0]           txData,
  input  logic                                   txErr
);

  localparam int IDX_W = $clog2(C_REQ_NUM);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} stateT;

  stateT                          state, nextState;
  logic [IDX_W-1:0]               lastWinner, nextLastWinner, winIdx;
  logic [IDX_W:0]                 cand;
  logic                           winFound, startByte, timeoutHit;
  logic                           lockedIdle, ownerLock;
  logic [CNT_W-1:0]               timeoutCnt, nextTimeoutCnt;
  logic                           txErrQ, txErrRise;
  logic [C_REQ_NUM-1:0]           nextGrant, nextReqAck;
  logic                           nextTxSend, nextError;
  logic [C_UART_DATA_WIDTH-1:0]   nextTxData;

`ifdef UART_ARB_LOCK_EN
  // A grant still held in IDLE means the last owner locked the UART for its message.
  assign ownerLock  = reqLock[lastWinner];
  assign lockedIdle = (state == IDLE) && (grant != '0);
`else
  logic unusedLock;
  assign unusedLock = ^reqLock;
  assign ownerLock  = 1'b0;
  assign lockedIdle = 1'b0;
`endif

  assign txErrRise  = txErr && !txErrQ;
  assign startByte  = (state == IDLE) && enable && winFound;
  assign timeoutHit = (state == SEND) && !txBusy &&
                      (timeoutCnt == CNT_W'(C_BUSY_TIMEOUT - 1));

  // Winner search starts one past the last winner and wraps at C_REQ_NUM.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    winFound = 1'b0;
    winIdx   = lastWinner;
    cand     = '0;
    if (lockedIdle) begin
      winFound = ownerLock && reqSend[lastWinner];
    end else begin
      for (int k = 1; k <= C_REQ_NUM; k++) begin
        cand = {1'b0, lastWinner} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(C_REQ_NUM)) cand = cand - (IDX_W+1)'(C_REQ_NUM);
        if (!winFound && reqSend[cand[IDX_W-1:0]]) begin
          winFound = 1'b1;
          winIdx   = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startByte) nextState = SEND;
      SEND:    if (txBusy) nextState = WAIT;
               else if (timeoutHit) nextState = IDLE;
      WAIT:    if (!txBusy) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    nextGrant      = grant;
    nextReqAck     = '0;
    nextTxSend     = txSend;
    nextTxData     = txData;
    nextLastWinner = lastWinner;
    nextTimeoutCnt = timeoutCnt;
    nextError      = txErrRise && (state != IDLE);
    case (state)
      IDLE: begin
        if (startByte) begin
          nextGrant          = '0;
          nextGrant[winIdx]  = 1'b1;
          nextReqAck[winIdx] = 1'b1;
          nextTxSend         = 1'b1;
          nextTxData         = reqData[winIdx*C_UART_DATA_WIDTH +: C_UART_DATA_WIDTH];
          nextLastWinner     = winIdx;
          nextTimeoutCnt     = '0;
        end else if (lockedIdle && !ownerLock) begin
          nextGrant = '0;
        end
      end
      SEND: begin
        if (txBusy) begin
          nextTxSend = 1'b0;
        end else if (timeoutHit) begin
          // Byte is dropped; lastWinner is left pointing at this requester.
          nextTxSend = 1'b0;
          nextGrant  = '0;
          nextError  = 1'b1;
        end else begin
          nextTimeoutCnt = timeoutCnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (!txBusy && !ownerLock) nextGrant = '0;
      end
      default: nextGrant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments, and every flop has a reset value.
    if (!rstb) begin
      state      <= IDLE;
      grant      <= '0;
      reqAck     <= '0;
      txSend     <= 1'b0;
      txData     <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
      timeoutCnt <= '0;
      lastWinner <= IDX_W'(C_REQ_NUM - 1);
      txErrQ     <= 1'b0;
    end else begin
      state      <= nextState;
      grant      <= nextGrant;
      reqAck     <= nextReqAck;
      txSend     <= nextTxSend;
      txData     <= nextTxData;
      busy       <= (nextState != IDLE);
      error      <= nextError;
      timeoutCnt <= nextTimeoutCnt;
      lastWinner <= nextLastWinner;
      txErrQ     <= txErr;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART_Tx busy model.
// Lock expectations follow UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstb, enable, txBusy, txErr, txSend, busy, error;
  logic [N-1:0]   reqSend, reqLock, reqAck, grant;
  logic [N*W-1:0] reqData;
  logic [W-1:0]   txData;

  uart_tx_arbiter #(
    .C_UART_DATA_WIDTH(W),
    .C_REQ_NUM(N),
    .C_BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstb(rstb), .enable(enable),
    .reqSend(reqSend), .reqData(reqData), .reqLock(reqLock),
    .reqAck(reqAck), .grant(grant), .busy(busy), .error(error),
    .txBusy(txBusy), .txSend(txSend), .txData(txData), .txErr(txErr)
  );

  always #5 clk = ~clk;

  // UART_Tx model: raises txBusy the negedge after txSend, holds it busyLen negedges.
  bit modelOn = 1'b0;
  int busyLen = 3;
  int holdCnt = 0;
  always @(negedge clk) begin
    if (!modelOn) begin
      txBusy  <= 1'b0;
      holdCnt <= 0;
    end else if (txBusy) begin
      if (holdCnt <= 1) txBusy <= 1'b0;
      holdCnt <= holdCnt - 1;
    end else if (txSend) begin
      txBusy  <= 1'b1;
      holdCnt <= busyLen;
    end
  end

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int ackIdx(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic waitAck(output int idx, input int budget);
    idx = -1;
    for (int i = 0; i < budget && idx < 0; i++) begin
      @(negedge clk);
      if (reqAck != '0) idx = ackIdx(reqAck);
    end
    check("ack_seen", 32'(reqAck != '0), 1);
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check("idle_reached", 32'(busy), 0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] expGrant;
    logic [W-1:0] expData;
  } vecT;

  vecT tbl[9];

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, cnt, sent2, nAck;
    int got[10];
    int expSeq[10];

    // Requester data: i -> 8'h31 + i. Pointer starts at 3, so the search starts at 0.
    tbl[0] = '{4'b0001, 4'b0001, 8'h31};
    tbl[1] = '{4'b1111, 4'b0010, 8'h32};
    tbl[2] = '{4'b1111, 4'b0100, 8'h33};
    tbl[3] = '{4'b1001, 4'b1000, 8'h34};
    tbl[4] = '{4'b0110, 4'b0010, 8'h32};
    tbl[5] = '{4'b0001, 4'b0001, 8'h31};
    tbl[6] = '{4'b1000, 4'b1000, 8'h34};
    tbl[7] = '{4'b0100, 4'b0100, 8'h33};
    tbl[8] = '{4'b0011, 4'b0001, 8'h31};

    rstb = 1'b0; enable = 1'b1; reqSend = '0; reqLock = '0; txErr = 1'b0;
    reqData = {8'h34, 8'h33, 8'h32, 8'h31};
    repeat (2) @(negedge clk);
    check("rst_txSend", 32'(txSend), 0);
    check("rst_txData", 32'(txData), 0);
    check("rst_grant",  32'(grant),  0);
    check("rst_reqAck", 32'(reqAck), 0);
    check("rst_busy",   32'(busy),   0);
    check("rst_error",  32'(error),  0);
    rstb = 1'b1;
    modelOn = 1'b1;

    // Single-byte transactions; each must ack exactly one clock after the request.
    for (int v = 0; v < 9; v++) begin
      reqSend = tbl[v].req;
      @(negedge clk);
      check($sformatf("v%0d_ack", v),    32'(reqAck), 32'(tbl[v].expGrant));
      check($sformatf("v%0d_grant", v),  32'(grant),  32'(tbl[v].expGrant));
      check($sformatf("v%0d_txData", v), 32'(txData), 32'(tbl[v].expData));
      check($sformatf("v%0d_txSend", v), 32'(txSend), 1);
      check($sformatf("v%0d_busy", v),   32'(busy),   1);
      reqSend = '0;
      @(negedge clk);
      check($sformatf("v%0d_ack_1clk", v), 32'(reqAck), 0);
      check($sformatf("v%0d_data_hold", v), 32'(txData), 32'(tbl[v].expData));
      waitIdle(20);
      check($sformatf("v%0d_grant_clr", v), 32'(grant), 0);
    end

    // Busy timeout: txBusy never rises, error exactly 16 clocks after txSend rise.
    modelOn = 1'b0;
    reqSend = 4'b0100;
    @(negedge clk);
    check("to_ack", 32'(reqAck), 32'(4'b0100));
    reqSend = '0;
    cnt = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (error || !txSend) cnt++;
    end
    check("to_early", cnt, 0);
    @(negedge clk);
    check("to_error",  32'(error),  1);
    check("to_txSend", 32'(txSend), 0);
    check("to_busy",   32'(busy),   0);
    check("to_grant",  32'(grant),  0);
    @(negedge clk);
    check("to_pulse",  32'(error),  0);
    // Dropped byte still moved the pointer to 2, so 0 beats 2 here.
    modelOn = 1'b1;
    reqSend = 4'b0101;
    @(negedge clk);
    check("to_lastwinner", 32'(reqAck), 32'(4'b0001));
    reqSend = '0;
    waitIdle(20);

    // txErr held two clocks during WAIT: one error pulse, byte completes.
    busyLen = 6;
    reqSend = 4'b0010;
    @(negedge clk);
    check("err_ack", 32'(reqAck), 32'(4'b0010));
    reqSend = '0;
    @(negedge clk);
    check("err_in_wait", 32'({busy, txSend}), 2);
    txErr = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      @(negedge clk);
      if (error) cnt++;
      if (i == 1) txErr = 1'b0;
      if (i == 2) check("err_grant_hold", 32'(grant), 32'(4'b0010));
    end
    check("err_pulses", cnt, 1);
    check("err_busy",  32'(busy),  0);
    check("err_grant", 32'(grant), 0);

    // enable low blocks IDLE exit but does not abort an in-flight byte.
    enable = 1'b0;
    reqSend = 4'b0001;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (reqAck != '0 || busy) cnt++;
    end
    check("en_block", cnt, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_ack", 32'(reqAck), 32'(4'b0001));
    enable = 1'b0;
    reqSend = '0;
    waitIdle(20);
    check("en_grant", 32'(grant), 0);
    enable = 1'b1;

    // Reset asserted during WAIT.
    busyLen = 8;
    reqSend = 4'b0010;
    @(negedge clk);
    check("rw_ack", 32'(reqAck), 32'(4'b0010));
    reqSend = '0;
    repeat (2) @(negedge clk);
    check("rw_in_wait", 32'({busy, txSend}), 2);
    rstb = 1'b0;
    #1;
    check("rw_txSend", 32'(txSend), 0);
    check("rw_txData", 32'(txData), 0);
    check("rw_grant",  32'(grant),  0);
    check("rw_reqAck", 32'(reqAck), 0);
    check("rw_busy",   32'(busy),   0);
    check("rw_error",  32'(error),  0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (error) cnt++;
    end
    rstb = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (error) cnt++;
    end
    check("rw_no_error", cnt, 0);

    // All four requesting: strict rotation starting at 0 after reset.
    busyLen = 2;
    reqSend = 4'b1111;
    for (int b = 0; b < 8; b++) begin
      waitAck(idx, 30);
      check($sformatf("rr%0d_winner", b), idx, b % 4);
    end
    reqSend = '0;
    waitIdle(30);

    // Requester 2 sends "12345" (lock high) while requester 0 also requests.
`ifdef UART_ARB_LOCK_EN
    nAck = 6;
    expSeq = '{2, 2, 2, 2, 2, 0, 0, 0, 0, 0};
`else
    nAck = 10;
    expSeq = '{2, 0, 2, 0, 2, 0, 2, 0, 2, 0};
`endif
    reqData[0 +: 8]  = 8'hA0;
    reqData[16 +: 8] = 8'h31;
    reqSend = 4'b0100;
    reqLock = 4'b0100;
    sent2 = 0;
    for (int a = 0; a < nAck; a++) begin
      waitAck(idx, 40);
      got[a] = idx;
      if (idx == 2) begin
        check($sformatf("lk_data%0d", sent2), 32'(txData), 32'h31 + sent2);
        sent2++;
        reqData[16 +: 8] = W'(8'h31 + sent2);
        if (sent2 == 5) begin
          reqSend[2] = 1'b0;
          reqLock[2] = 1'b0;
        end
      end
      if (a == 0) reqSend[0] = 1'b1;
    end
    reqSend = '0;
    waitIdle(40);
    for (int a = 0; a < nAck; a++)
      check($sformatf("lk_order%0d", a), got[a], expSeq[a]);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
